// File: rtl/estacao_reserva.sv
// rtl/estacao_reserva.sv - two-entry reservation station feeding one arithmetic unit
// Entries wait on producer tags, snoop the CDB, dispatch in index order and broadcast their result.
module estacao_reserva #(
  parameter int LARGURA = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               emite,
  output logic               livre,
  input  logic [2:0]         op_in,
  input  logic [LARGURA-1:0] vj,
  input  logic [LARGURA-1:0] vk,
  input  logic [2:0]         qj,
  input  logic [2:0]         qk,
  input  logic [2:0]         tag_in,
  input  logic               cdb_valido,
  input  logic [2:0]         cdb_tag,
  input  logic [LARGURA-1:0] cdb_dado,
  output logic [2:0]         op,
  output logic [LARGURA-1:0] dado1,
  output logic [LARGURA-1:0] dado2,
  input  logic [LARGURA-1:0] resultado,
  output logic               pede_cdb,
  output logic [2:0]         saida_tag,
  output logic [LARGURA-1:0] saida_dado,
  input  logic               cdb_concede
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, ESPERA_CDB} estado_t;

  estado_t estado, proximo;

  logic [1:0]         ocupada;
  logic [1:0]         executando;
  logic [2:0]         op_e  [2];
  logic [LARGURA-1:0] vj_e  [2];
  logic [LARGURA-1:0] vk_e  [2];
  logic [2:0]         qj_e  [2];
  logic [2:0]         qk_e  [2];
  logic [2:0]         tag_e [2];
  logic               sel;

  logic       cdb_ativo;
  logic       emite_ok;
  logic       idx_livre;
  logic [1:0] pronta;
  logic       idx_pronta;
  logic       despacha;
  logic       transmite;
  logic       libera;

  // A tag of zero means "no producer", so it never matches a waiting operand.
  assign cdb_ativo  = cdb_valido && (cdb_tag != 3'd0);
  assign livre      = ~(ocupada[0] & ocupada[1]);
  assign emite_ok   = emite && livre && (op_in != 3'd0) && (op_in <= 3'd4) && (tag_in != 3'd0);
  assign idx_livre  = ocupada[0];
  assign pronta[0]  = ocupada[0] && !executando[0] && (qj_e[0] == 3'd0) && (qk_e[0] == 3'd0);
  assign pronta[1]  = ocupada[1] && !executando[1] && (qj_e[1] == 3'd0) && (qk_e[1] == 3'd0);
  assign idx_pronta = ~pronta[0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) estado <= OCIOSO;
    else         estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:     if (|pronta) proximo = EXECUTA;
      EXECUTA:    proximo = ESPERA_CDB;
      ESPERA_CDB: if (cdb_concede) proximo = OCIOSO;
      default:    proximo = OCIOSO;
    endcase
  end

  always_comb begin
    despacha  = 1'b0;
    transmite = 1'b0;
    libera    = 1'b0;
    case (estado)
      OCIOSO:     despacha  = |pronta;
      EXECUTA:    transmite = 1'b1;
      ESPERA_CDB: libera    = cdb_concede;
      default:    ;
    endcase
  end

  // The freed entry (sel) is always occupied while the issue target is free, so they never collide.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ocupada    <= 2'b00;
      executando <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        op_e[i]  <= 3'd0;
        vj_e[i]  <= '0;
        vk_e[i]  <= '0;
        qj_e[i]  <= 3'd0;
        qk_e[i]  <= 3'd0;
        tag_e[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ocupada[i] && cdb_ativo && (qj_e[i] == cdb_tag)) begin
          vj_e[i] <= cdb_dado;
          qj_e[i] <= 3'd0;
        end
        if (ocupada[i] && cdb_ativo && (qk_e[i] == cdb_tag)) begin
          vk_e[i] <= cdb_dado;
          qk_e[i] <= 3'd0;
        end
        if (emite_ok && (idx_livre == 1'(i))) begin
          ocupada[i]    <= 1'b1;
          executando[i] <= 1'b0;
          op_e[i]       <= op_in;
          tag_e[i]      <= tag_in;
          if (cdb_ativo && (qj == cdb_tag)) begin
            vj_e[i] <= cdb_dado;
            qj_e[i] <= 3'd0;
          end else begin
            vj_e[i] <= vj;
            qj_e[i] <= qj;
          end
          if (cdb_ativo && (qk == cdb_tag)) begin
            vk_e[i] <= cdb_dado;
            qk_e[i] <= 3'd0;
          end else begin
            vk_e[i] <= vk;
            qk_e[i] <= qk;
          end
        end
        if (despacha && (idx_pronta == 1'(i))) executando[i] <= 1'b1;
        if (libera && (sel == 1'(i))) begin
          ocupada[i]    <= 1'b0;
          executando[i] <= 1'b0;
        end
      end
    end
  end

  // Op is a one-cycle pulse; operands and the broadcast payload hold until overwritten.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op         <= 3'd0;
      dado1      <= '0;
      dado2      <= '0;
      sel        <= 1'b0;
      pede_cdb   <= 1'b0;
      saida_tag  <= 3'd0;
      saida_dado <= '0;
    end else begin
      op <= despacha ? op_e[idx_pronta] : 3'd0;
      if (despacha) begin
        dado1 <= vj_e[idx_pronta];
        dado2 <= vk_e[idx_pronta];
        sel   <= idx_pronta;
      end
      if (transmite) begin
        pede_cdb   <= 1'b1;
        saida_tag  <= tag_e[sel];
        saida_dado <= resultado;
      end else if (libera) begin
        pede_cdb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_estacao_reserva.sv
// tb/tb_estacao_reserva.sv - directed self-checking bench for estacao_reserva
// An external adder/subtractor model stands in for the arithmetic unit.
module tb_estacao_reserva;

  logic        clock;
  logic        resetn;
  logic        emite;
  logic        livre;
  logic [2:0]  op_in;
  logic [15:0] vj, vk;
  logic [2:0]  qj, qk, tag_in;
  logic        cdb_valido;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_dado;
  logic [2:0]  op;
  logic [15:0] dado1, dado2;
  logic [15:0] resultado;
  logic        pede_cdb;
  logic [2:0]  saida_tag;
  logic [15:0] saida_dado;
  logic        cdb_concede;

  int total = 0;
  int bad   = 0;

  estacao_reserva #(.LARGURA(16)) dut (
    .clock(clock), .resetn(resetn), .emite(emite), .livre(livre),
    .op_in(op_in), .vj(vj), .vk(vk), .qj(qj), .qk(qk), .tag_in(tag_in),
    .cdb_valido(cdb_valido), .cdb_tag(cdb_tag), .cdb_dado(cdb_dado),
    .op(op), .dado1(dado1), .dado2(dado2), .resultado(resultado),
    .pede_cdb(pede_cdb), .saida_tag(saida_tag), .saida_dado(saida_dado),
    .cdb_concede(cdb_concede)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb resultado = (op == 3'd2) ? (dado1 - dado2) : (dado1 + dado2);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic emitir(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] ja, input logic [2:0] ka, input logic [2:0] t);
    emite = 1'b1; op_in = o; vj = a; vk = b; qj = ja; qk = ka; tag_in = t;
  endtask

  task automatic parar();
    emite = 1'b0; op_in = 3'd0; vj = '0; vk = '0; qj = 3'd0; qk = 3'd0; tag_in = 3'd0;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    cdb_valido = v; cdb_tag = t; cdb_dado = d;
  endtask

  task automatic test_reset();
    #3;
    total++; if (livre !== 1'b1) begin bad++; $display("FAIL reset_livre got=%b want=1", livre); end
    total++; if (pede_cdb !== 1'b0) begin bad++; $display("FAIL reset_pede got=%b want=0", pede_cdb); end
    total++; if (op !== 3'd0) begin bad++; $display("FAIL reset_op got=%0d want=0", op); end
    total++; if ({dado1, dado2, saida_dado} !== 48'd0) begin bad++; $display("FAIL reset_dados got=%h want=0", {dado1, dado2, saida_dado}); end
    total++; if (saida_tag !== 3'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", saida_tag); end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_add();
    cdb_concede = 1'b1;
    emitir(3'd1, 16'd5, 16'd7, 3'd0, 3'd0, 3'd3);
    step();
    parar();
    total++; if (op !== 3'd0) begin bad++; $display("FAIL add_op_early got=%0d want=0", op); end
    step();
    total++; if ({op, dado1, dado2} !== {3'd1, 16'd5, 16'd7}) begin bad++; $display("FAIL add_dispatch got=%h want=%h", {op, dado1, dado2}, {3'd1, 16'd5, 16'd7}); end
    total++; if (pede_cdb !== 1'b0) begin bad++; $display("FAIL add_pede_early got=%b want=0", pede_cdb); end
    step();
    total++; if ({pede_cdb, saida_tag, saida_dado} !== {1'b1, 3'd3, 16'd12}) begin bad++; $display("FAIL add_broadcast got=%h want=%h", {pede_cdb, saida_tag, saida_dado}, {1'b1, 3'd3, 16'd12}); end
    total++; if (op !== 3'd0) begin bad++; $display("FAIL add_op_clear got=%0d want=0", op); end
    step();
    total++; if ({pede_cdb, livre} !== 2'b01) begin bad++; $display("FAIL add_freed got=%b want=01", {pede_cdb, livre}); end
    cdb_concede = 1'b0;
  endtask

  task automatic test_drop();
    emitir(3'd0, 16'd1, 16'd1, 3'd0, 3'd0, 3'd1); step();
    emitir(3'd5, 16'd1, 16'd1, 3'd0, 3'd0, 3'd1); step();
    emitir(3'd1, 16'd1, 16'd1, 3'd0, 3'd0, 3'd0); step();
    parar(); step();
    total++; if ({op, pede_cdb} !== 4'd0) begin bad++; $display("FAIL drop_no_dispatch got=%h want=0", {op, pede_cdb}); end
    step(); step();
    total++; if ({op, pede_cdb} !== 4'd0) begin bad++; $display("FAIL drop_no_broadcast got=%h want=0", {op, pede_cdb}); end
  endtask

  task automatic test_snoop();
    emitir(3'd1, 16'd0, 16'd4, 3'd2, 3'd0, 3'd1);
    step();
    parar();
    step(); step();
    total++; if (op !== 3'd0) begin bad++; $display("FAIL snoop_wait got=%0d want=0", op); end
    cdb(1'b1, 3'd2, 16'd10);
    step();
    cdb(1'b0, 3'd0, 16'd0);
    step();
    total++; if ({op, dado1, dado2} !== {3'd1, 16'd10, 16'd4}) begin bad++; $display("FAIL snoop_dispatch got=%h want=%h", {op, dado1, dado2}, {3'd1, 16'd10, 16'd4}); end
    step();
    total++; if ({pede_cdb, saida_tag, saida_dado} !== {1'b1, 3'd1, 16'd14}) begin bad++; $display("FAIL snoop_broadcast got=%h want=%h", {pede_cdb, saida_tag, saida_dado}, {1'b1, 3'd1, 16'd14}); end
    cdb_concede = 1'b1;
    step();
    cdb_concede = 1'b0;
  endtask

  task automatic test_forward();
    emitir(3'd1, 16'd0, 16'd1, 3'd2, 3'd0, 3'd4);
    cdb(1'b1, 3'd2, 16'd9);
    step();
    parar();
    cdb(1'b0, 3'd0, 16'd0);
    step();
    total++; if ({op, dado1, dado2} !== {3'd1, 16'd9, 16'd1}) begin bad++; $display("FAIL fwd_dispatch got=%h want=%h", {op, dado1, dado2}, {3'd1, 16'd9, 16'd1}); end
    step();
    total++; if ({pede_cdb, saida_tag, saida_dado} !== {1'b1, 3'd4, 16'd10}) begin bad++; $display("FAIL fwd_broadcast got=%h want=%h", {pede_cdb, saida_tag, saida_dado}, {1'b1, 3'd4, 16'd10}); end
    cdb_concede = 1'b1;
    step();
    cdb_concede = 1'b0;
  endtask

  task automatic test_full();
    emitir(3'd1, 16'd0, 16'd2, 3'd5, 3'd0, 3'd6); step();
    emitir(3'd1, 16'd0, 16'd3, 3'd6, 3'd0, 3'd7); step();
    parar();
    total++; if (livre !== 1'b0) begin bad++; $display("FAIL full_livre got=%b want=0", livre); end
    cdb(1'b1, 3'd5, 16'd1);
    step();
    cdb(1'b0, 3'd0, 16'd0);
    step();
    total++; if ({op, dado1, dado2} !== {3'd1, 16'd1, 16'd2}) begin bad++; $display("FAIL full_dispatch got=%h want=%h", {op, dado1, dado2}, {3'd1, 16'd1, 16'd2}); end
    emitir(3'd1, 16'd50, 16'd50, 3'd0, 3'd0, 3'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({pede_cdb, saida_tag, saida_dado, livre} !== {1'b1, 3'd6, 16'd3, 1'b0}) begin bad++; $display("FAIL full_hold%0d got=%h want=%h", i, {pede_cdb, saida_tag, saida_dado, livre}, {1'b1, 3'd6, 16'd3, 1'b0}); end
    end
    parar();
    cdb_concede = 1'b1;
    step();
    cdb_concede = 1'b0;
    total++; if ({pede_cdb, livre} !== 2'b01) begin bad++; $display("FAIL full_grant got=%b want=01", {pede_cdb, livre}); end
    step(); step(); step();
    total++; if ({op, pede_cdb} !== 4'd0) begin bad++; $display("FAIL full_no_self_snoop got=%h want=0", {op, pede_cdb}); end
    cdb(1'b1, 3'd6, 16'd3);
    step();
    cdb(1'b0, 3'd0, 16'd0);
    step();
    total++; if ({op, dado1, dado2} !== {3'd1, 16'd3, 16'd3}) begin bad++; $display("FAIL full_second got=%h want=%h", {op, dado1, dado2}, {3'd1, 16'd3, 16'd3}); end
    step();
    total++; if ({pede_cdb, saida_tag, saida_dado} !== {1'b1, 3'd7, 16'd6}) begin bad++; $display("FAIL full_second_bc got=%h want=%h", {pede_cdb, saida_tag, saida_dado}, {1'b1, 3'd7, 16'd6}); end
    cdb_concede = 1'b1;
    step();
    cdb_concede = 1'b0;
    step(); step();
    total++; if ({op, pede_cdb} !== 4'd0) begin bad++; $display("FAIL full_dropped_issue got=%h want=0", {op, pede_cdb}); end
  endtask

  task automatic test_sub_addr();
    emitir(3'd2, 16'd3, 16'd5, 3'd0, 3'd0, 3'd1);
    step(); parar(); step(); step();
    total++; if ({saida_tag, saida_dado} !== {3'd1, 16'hFFFE}) begin bad++; $display("FAIL sub_result got=%h want=%h", {saida_tag, saida_dado}, {3'd1, 16'hFFFE}); end
    cdb_concede = 1'b1;
    step();
    cdb_concede = 1'b0;
    emitir(3'd4, 16'd100, 16'd20, 3'd0, 3'd0, 3'd2);
    step(); parar(); step();
    total++; if (op !== 3'd4) begin bad++; $display("FAIL addr_op got=%0d want=4", op); end
    step();
    total++; if (saida_dado !== 16'd120) begin bad++; $display("FAIL addr_result got=%0d want=120", saida_dado); end
    cdb_concede = 1'b1;
    step();
    cdb_concede = 1'b0;
  endtask

  task automatic test_back_to_back();
    emitir(3'd1, 16'd2, 16'd3, 3'd0, 3'd0, 3'd1);
    step(); parar(); step(); step();
    emitir(3'd1, 16'd10, 16'd20, 3'd0, 3'd0, 3'd2);
    cdb_concede = 1'b1;
    step();
    parar();
    cdb_concede = 1'b0;
    total++; if ({pede_cdb, livre} !== 2'b01) begin bad++; $display("FAIL b2b_grant got=%b want=01", {pede_cdb, livre}); end
    step();
    total++; if ({op, dado1, dado2} !== {3'd1, 16'd10, 16'd20}) begin bad++; $display("FAIL b2b_dispatch got=%h want=%h", {op, dado1, dado2}, {3'd1, 16'd10, 16'd20}); end
    step();
    total++; if ({pede_cdb, saida_tag, saida_dado} !== {1'b1, 3'd2, 16'd30}) begin bad++; $display("FAIL b2b_broadcast got=%h want=%h", {pede_cdb, saida_tag, saida_dado}, {1'b1, 3'd2, 16'd30}); end
    cdb_concede = 1'b1;
    step();
    cdb_concede = 1'b0;
  endtask

  task automatic test_reset_mid();
    emitir(3'd1, 16'd1, 16'd1, 3'd0, 3'd0, 3'd5);
    step(); parar(); step(); step();
    total++; if (pede_cdb !== 1'b1) begin bad++; $display("FAIL mid_pede_before got=%b want=1", pede_cdb); end
    resetn = 1'b0;
    #1;
    total++; if ({pede_cdb, livre, op} !== {1'b0, 1'b1, 3'd0}) begin bad++; $display("FAIL mid_async got=%h want=%h", {pede_cdb, livre, op}, {1'b0, 1'b1, 3'd0}); end
    step();
    resetn = 1'b1;
    cdb_concede = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({pede_cdb, op} !== 4'd0) begin bad++; $display("FAIL mid_abandon%0d got=%h want=0", i, {pede_cdb, op}); end
    end
    cdb_concede = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    cdb_concede = 1'b0;
    parar();
    cdb(1'b0, 3'd0, 16'd0);
    test_reset();
    test_add();
    test_drop();
    test_snoop();
    test_forward();
    test_full();
    test_sub_addr();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
